note_player: RTL and testbench
==============================

// Module: note_player
// PURPOSE
// - Sequences one note at a time through the div-by-12 note decoder: accepts a 6-bit note number over a valid/ready handshake,
//   splits it into octave (quotient) and semitone (remainder), and produces a square-wave speaker output for a given duration.
// - Sits between the song ROM/sequencer and the audio pin; also drives octave/semitone to the display logic.
// PARAMETERS
// - TICK_CYCLES  default 250000  clk cycles per duration tick (prescaler terminal count)
// - GAP_TICKS    default 2       silent ticks inserted after every note
// - DUR_W        default 8       width of duration input
// PORTS
// - clk        in   1      system clock
// - rst_n      in   1      asynchronous active-low reset
// - note_valid in   1      note_num/duration/rest are valid
// - note_ready out  1      block can accept a note (high only in IDLE)
// - note_num   in   6      note number 0..63; octave = num/12, semitone = num%12
// - duration   in   DUR_W  note length in ticks
// - rest       in   1      1 = silence for duration, no tone
// - speaker    out  1      square-wave audio output
// - busy       out  1      high in LOAD/PLAY/GAP
// - octave     out  3      registered octave of current note
// - semitone   out  4      registered semitone of current note
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low on rst_n: all registers cleared, state=IDLE.
// - Reset values: note_ready=1 (combinational from IDLE), speaker=0, busy=0, octave=0, semitone=0.
// - Handshake: transfer when note_valid & note_ready on a rising clk edge; note_valid while busy is ignored (ready low).
// - FSM states:
//   IDLE -> LOAD on transfer; latch note_num, duration, rest.
//   LOAD (1 cycle): register octave/semitone from divider; reload half-period counter = (NOTE_HP[semitone] >> octave) - 1;
//     reset prescaler; load dur_cnt=duration. -> PLAY, or -> GAP directly if duration==0.
//   PLAY: tone counter decrements each clk; at 0 reloads and toggles speaker (suppressed when rest=1, speaker held 0).
//     Prescaler counts 0..TICK_CYCLES-1; at terminal count dur_cnt decrements; when dur_cnt reaches 0 -> GAP.
//   GAP: speaker forced 0; GAP_TICKS ticks counted via the same prescaler -> IDLE. GAP_TICKS=0 -> IDLE next cycle.
// - Latency: note accepted at edge N; LOAD at N+1; first speaker toggle at N+1+hp cycles; total busy = 1 + duration*TICK_CYCLES
//   + GAP_TICKS*TICK_CYCLES cycles (+-1 for state exits).
// - speaker returns to 0 on entry to GAP regardless of phase; it starts at 0 for every note.
// - Half-period arithmetic: NOTE_HP entries 11 bits; shift right by octave (0..5); result never below 16, so no zero reload.
// - note_num 60..63 decode to octave 5, semitone 0..3; legal, played normally.
// - rest=1: octave/semitone still updated; tone counter frozen.
// - Reset mid-note: immediately IDLE, speaker 0, pending note discarded.
// - octave/semitone hold their last value in GAP and IDLE until the next LOAD.
// STRUCTURE
// - Package note_pkg: state enum {IDLE,LOAD,PLAY,GAP}; NOTE_HP[0..11] half-period table at octave 0 in clk cycles:
//   1024,966,912,861,813,767,724,683,645,609,575,542; constants OCT_W=3, SEMI_W=4.
// - One sub-module: divby12 (combinational, note_num -> quotient/remainder), instantiated once on the latched note.
// - Prescaler, duration counter, tone counter and FSM live in note_player itself.
// TESTING (TICK_CYCLES=4, GAP_TICKS=2)
// - Reset: assert rst_n=0 mid-PLAY -> next cycle speaker=0, busy=0, note_ready=1, octave=0, semitone=0.
// - note_num=0, duration=3, rest=0 -> octave=0, semitone=0; speaker toggles every 1024 clks; busy high 1+12+8 cycles (+-1).
// - note_num=17 -> octave=1, semitone=5, half-period 767>>1=383 clks between speaker edges.
// - note_num=63 -> octave=5, semitone=3, half-period 861>>5=26 clks.
// - rest=1, duration=2 -> speaker stays 0 for whole note; busy for 1+8+8 cycles; octave/semitone still updated.
// - duration=0 -> LOAD then GAP directly, no toggle; second note_valid held during busy is accepted only after return to IDLE.

Source files
------------

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types, widths and half-period table for the note player
// Purpose: FSM state encoding, field widths and the octave-0 half-period table
//          (in clk cycles) used when loading the tone counter.
// Ports:   none (package)
package note_pkg;

   localparam int NOTE_W = 6;
   localparam int OCT_W  = 3;
   localparam int SEMI_W = 4;
   localparam int HP_W   = 11;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PLAY,
      GAP
   } state_t;

   // Half period at octave 0 for each semitone, in clk cycles.
   function automatic logic [HP_W-1:0] note_hp(input logic [SEMI_W-1:0] semi);
      logic [HP_W-1:0] hp;
      case (semi)
         4'd0:    hp = 11'd1024;
         4'd1:    hp = 11'd966;
         4'd2:    hp = 11'd912;
         4'd3:    hp = 11'd861;
         4'd4:    hp = 11'd813;
         4'd5:    hp = 11'd767;
         4'd6:    hp = 11'd724;
         4'd7:    hp = 11'd683;
         4'd8:    hp = 11'd645;
         4'd9:    hp = 11'd609;
         4'd10:   hp = 11'd575;
         4'd11:   hp = 11'd542;
         default: hp = 11'd1024;
      endcase
      return hp;
   endfunction

   // Tone counter reload value: half period scaled to the octave, minus one
   // because the counter spends one cycle at zero before toggling.
   // Smallest result is 542>>5 = 16, so the reload never underflows.
   function automatic logic [HP_W-1:0] half_period_m1(input logic [SEMI_W-1:0] semi,
                                                     input logic [OCT_W-1:0]  oct);
      return (note_hp(semi) >> oct) - 11'd1;
   endfunction

endpackage

// File: rtl/divby12.sv
// rtl/divby12.sv - combinational note number to octave/semitone decoder
// Purpose: splits a 6-bit note number into quotient (octave) and remainder
//          (semitone) of a division by 12.
// Ports:   num       in  6  note number 0..63
//          quotient  out 3  num / 12 (0..5)
//          remainder out 4  num % 12 (0..11)
module divby12
   import note_pkg::*;
(
   input  logic [NOTE_W-1:0] num,
   output logic [OCT_W-1:0]  quotient,
   output logic [SEMI_W-1:0] remainder
);

   logic [NOTE_W-1:0] base;

   // Range compare instead of a divider: only six possible quotients.
   always_comb begin
      quotient = 3'd0;
      base     = 6'd0;
      if (num >= 6'd60) begin
         quotient = 3'd5;
         base     = 6'd60;
      end else if (num >= 6'd48) begin
         quotient = 3'd4;
         base     = 6'd48;
      end else if (num >= 6'd36) begin
         quotient = 3'd3;
         base     = 6'd36;
      end else if (num >= 6'd24) begin
         quotient = 3'd2;
         base     = 6'd24;
      end else if (num >= 6'd12) begin
         quotient = 3'd1;
         base     = 6'd12;
      end
      remainder = SEMI_W'(num - base);
   end

endmodule

// File: rtl/note_player.sv
// rtl/note_player.sv - one-note-at-a-time square-wave sequencer
// Purpose: accepts a note over valid/ready, decodes octave/semitone, plays a
//          square wave (or silence for a rest) for a number of ticks, then
//          inserts a fixed silent gap before accepting the next note.
// Ports:   clk         in  1      system clock
//          rst_n       in  1      asynchronous active-low reset
//          note_valid  in  1      note_num/duration/rest valid
//          note_ready  out 1      high only in IDLE
//          note_num    in  6      note number 0..63
//          duration    in  DUR_W  note length in ticks
//          rest        in  1      1 = silent note
//          speaker     out 1      square-wave audio output
//          busy        out 1      high in LOAD/PLAY/GAP
//          octave      out 3      octave of current/last note
//          semitone    out 4      semitone of current/last note
module note_player
   import note_pkg::*;
#(
   parameter int TICK_CYCLES = 250000,
   parameter int GAP_TICKS   = 2,
   parameter int DUR_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              note_valid,
   output logic              note_ready,
   input  logic [5:0]        note_num,
   input  logic [DUR_W-1:0]  duration,
   input  logic              rest,
   output logic              speaker,
   output logic              busy,
   output logic [2:0]        octave,
   output logic [3:0]        semitone
);

   localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   state_t             state;
   logic [NOTE_W-1:0]  num_q;
   logic [DUR_W-1:0]   dur_q;
   logic               rest_q;
   logic [DUR_W-1:0]   dur_cnt;
   logic [HP_W-1:0]    hp_cnt;
   logic [HP_W-1:0]    hp_reload;
   logic [PRE_W-1:0]   presc;
   logic [GAP_W-1:0]   gap_cnt;
   logic [OCT_W-1:0]   div_q;
   logic [SEMI_W-1:0]  div_r;
   logic               tick;

   divby12 u_divby12 (
      .num       (num_q),
      .quotient  (div_q),
      .remainder (div_r)
   );

   assign note_ready = (state == IDLE);
   assign tick       = (presc == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         num_q     <= '0;
         dur_q     <= '0;
         rest_q    <= 1'b0;
         dur_cnt   <= '0;
         hp_cnt    <= '0;
         hp_reload <= '0;
         presc     <= '0;
         gap_cnt   <= '0;
         speaker   <= 1'b0;
         busy      <= 1'b0;
         octave    <= '0;
         semitone  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (note_valid) begin
                  num_q  <= note_num;
                  dur_q  <= duration;
                  rest_q <= rest;
                  busy   <= 1'b1;
                  state  <= LOAD;
               end
            end

            LOAD: begin
               octave    <= div_q;
               semitone  <= div_r;
               hp_reload <= half_period_m1(div_r, div_q);
               hp_cnt    <= half_period_m1(div_r, div_q);
               presc     <= '0;
               gap_cnt   <= '0;
               dur_cnt   <= dur_q;
               speaker   <= 1'b0;
               state     <= (dur_q == '0) ? GAP : PLAY;
            end

            PLAY: begin
               // Rests freeze the tone counter so speaker stays low.
               if (!rest_q) begin
                  if (hp_cnt == '0) begin
                     hp_cnt  <= hp_reload;
                     speaker <= ~speaker;
                  end else begin
                     hp_cnt <= hp_cnt - 1'b1;
                  end
               end
               if (tick) begin
                  presc   <= '0;
                  dur_cnt <= dur_cnt - 1'b1;
                  // Leaving for GAP overrides any toggle on this edge.
                  if (dur_cnt == DUR_W'(1)) begin
                     speaker <= 1'b0;
                     state   <= GAP;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end

            GAP: begin
               speaker <= 1'b0;
               if (GAP_TICKS == 0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (tick) begin
                  presc <= '0;
                  if (gap_cnt == GAP_LAST) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - directed self-checking bench for note_player
module tb_note_player;

   logic       clk;
   logic       rst_n;
   logic       note_valid;
   logic       note_ready;
   logic [5:0] note_num;
   logic [7:0] duration;
   logic       rest;
   logic       speaker;
   logic       busy;
   logic [2:0] octave;
   logic [3:0] semitone;

   int checks = 0;
   int errors = 0;

   note_player #(
      .TICK_CYCLES (4),
      .GAP_TICKS   (2),
      .DUR_W       (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .note_num   (note_num),
      .duration   (duration),
      .rest       (rest),
      .speaker    (speaker),
      .busy       (busy),
      .octave     (octave),
      .semitone   (semitone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!note_ready && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!note_ready) check({tag, "_ready_timeout"}, 0, 1);
   endtask

   // Plays one note; returns busy length (samples from the transfer edge on),
   // sample index of the first two speaker changes (-1 if none), and the
   // highest speaker level seen.
   task automatic run_note(input logic [5:0] num, input logic [7:0] dur, input logic r,
                           output int busy_cyc, output int t1, output int t2,
                           output int spk_max);
      int  k;
      logic prev;
      wait_ready("run_note");
      note_num   = num;
      duration   = dur;
      rest       = r;
      note_valid = 1'b1;
      @(posedge clk);
      #1;
      note_valid = 1'b0;
      k = 0;
      busy_cyc = 0;
      t1 = -1;
      t2 = -1;
      spk_max = 0;
      prev = speaker;
      while (busy && k < 3000) begin
         busy_cyc++;
         @(posedge clk);
         #1;
         k++;
         if (speaker) spk_max = 1;
         if (speaker !== prev) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
            prev = speaker;
         end
      end
   endtask

   int bc, t1, t2, sm, k;
   logic pre;

   initial begin
      rst_n      = 1'b0;
      note_valid = 1'b0;
      note_num   = '0;
      duration   = '0;
      rest       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_speaker", speaker, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", note_ready, 1);
      check("rst_octave", octave, 0);
      check("rst_semitone", semitone, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // note 0, 3 ticks: 1 + 12 + 8 busy cycles, no toggle within 12 cycles
      run_note(6'd0, 8'd3, 1'b0, bc, t1, t2, sm);
      check("n0_busy", bc, 21);
      check("n0_octave", octave, 0);
      check("n0_semitone", semitone, 0);
      check("n0_no_toggle", t1, -1);

      // note 17: half period 383, first edge at 1+383
      run_note(6'd17, 8'd255, 1'b0, bc, t1, t2, sm);
      check("n17_octave", octave, 1);
      check("n17_semitone", semitone, 5);
      check("n17_first_edge", t1, 384);
      check("n17_half_period", t2 - t1, 383);
      check("n17_busy", bc, 1029);
      check("n17_spk_end", speaker, 0);

      // note 63: half period 26
      run_note(6'd63, 8'd20, 1'b0, bc, t1, t2, sm);
      check("n63_octave", octave, 5);
      check("n63_semitone", semitone, 3);
      check("n63_first_edge", t1, 27);
      check("n63_half_period", t2 - t1, 26);
      check("n63_busy", bc, 89);
      check("n63_spk_end", speaker, 0);

      // rest: silent, decode still updated
      run_note(6'd40, 8'd2, 1'b1, bc, t1, t2, sm);
      check("rest_octave", octave, 3);
      check("rest_semitone", semitone, 4);
      check("rest_busy", bc, 17);
      check("rest_spk_max", sm, 0);

      // duration 0 with a second note held valid while busy
      wait_ready("dur0");
      note_num   = 6'd5;
      duration   = 8'd0;
      rest       = 1'b0;
      note_valid = 1'b1;
      @(posedge clk);
      #1;
      note_num = 6'd30;
      duration = 8'd1;
      k  = 0;
      sm = 0;
      pre = 1'b0;
      while (k < 200) begin
         pre = note_ready;
         @(posedge clk);
         #1;
         k++;
         if (speaker) sm = 1;
         if (k == 1) begin
            check("d0_octave", octave, 0);
            check("d0_semitone", semitone, 5);
         end
         if (pre) break;
      end
      note_valid = 1'b0;
      check("d0_second_accept_edge", k, 10);
      check("d0_spk_max", sm, 0);
      @(posedge clk);
      #1;
      check("held_octave", octave, 2);
      check("held_semitone", semitone, 6);
      wait_ready("held");

      // reset in the middle of a tone while speaker is high
      note_num   = 6'd63;
      duration   = 8'd20;
      rest       = 1'b0;
      note_valid = 1'b1;
      @(posedge clk);
      #1;
      note_valid = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
      end
      check("mid_spk_high", speaker, 1);
      check("mid_busy_high", busy, 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_speaker", speaker, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", note_ready, 1);
      check("mid_rst_octave", octave, 0);
      check("mid_rst_semitone", semitone, 0);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("post_rst_idle_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
